// File: rtl/data_ram_pkg.sv
// Shared definitions for the data RAM slave: FSM state encoding and the
// wait-state counter width.
package data_ram_pkg;

  // Width of the wait-state counter; holds WAIT_CYCLES values 0..15.
  localparam int CNT_W = 4;

  // Access handshake states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/data_ram_array.sv
// Byte-lane writable 32-bit word storage with a registered (synchronous)
// read port. The storage itself is never reset; only the read register is.
module data_ram_array #(
  parameter int ADDR_W = 10
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_en,
  input  logic              i_rd_en,
  input  logic              i_rd_zero,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [3:0]        i_sel,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata
);

  logic [31:0] r_mem [2**ADDR_W];
  logic [31:0] r_rdata;

  // Byte-lane write into the storage array (no reset on contents).
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (i_sel[b]) begin
          r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  // Read register: loads on a read access and holds until the next one.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdata <= 32'h0000_0000;
    end else if (i_rd_en) begin
      r_rdata <= i_rd_zero ? 32'h0000_0000 : r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_ram_slave.sv
// Data RAM slave for the MEM stage: one access per request with a
// configurable number of wait states, a single RESP cycle after each
// access, and abort on request withdrawal during the wait phase.
// Optional feature: define DATA_RAM_RANGE_CHK_EN to flag accesses whose
// address bits above the array depth are nonzero (write suppressed, read
// returns 0, err_o pulses in RESP). Without it, upper bits alias.
import data_ram_pkg::*;

module data_ram_slave #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ram_ce_i,
  input  logic        ram_we_i,
  input  logic [31:0] ram_addr_i,
  input  logic [3:0]  ram_sel_i,
  input  logic [31:0] ram_wdata_i,
  output logic [31:0] ram_data_o,
  output logic        stall_o,
  output logic        err_o
);

`ifdef DATA_RAM_RANGE_CHK_EN
  localparam logic RANGE_CHK = 1'b1;
`else
  localparam logic RANGE_CHK = 1'b0;
`endif

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_we;
  logic [3:0]       r_sel;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic             r_err;

  logic             w_do_acc;
  logic             w_we;
  logic [3:0]       w_sel;
  logic [31:0]      w_addr;
  logic [31:0]      w_wdata;
  logic             w_oor;
  logic             w_wr_en;
  logic             w_rd_en;
  logic [31:0]      w_rdata;

  // Decide whether the access fires on this edge and pick its operands:
  // live inputs when firing straight out of IDLE, latched copies otherwise.
  always_comb begin
    w_do_acc = 1'b0;
    case (r_state)
      IDLE:    w_do_acc = ram_ce_i && (WAIT_CYCLES == 0);
      WAIT:    w_do_acc = ram_ce_i && (r_cnt == CNT_W'(1));
      default: w_do_acc = 1'b0;
    endcase
    if (r_state == IDLE) begin
      w_we    = ram_we_i;
      w_sel   = ram_sel_i;
      w_addr  = ram_addr_i;
      w_wdata = ram_wdata_i;
    end else begin
      w_we    = r_we;
      w_sel   = r_sel;
      w_addr  = r_addr;
      w_wdata = r_wdata;
    end
  end

  // Out-of-range flag is only meaningful when the range check is built in.
  assign w_oor   = RANGE_CHK && ((w_addr >> (ADDR_W + 2)) != 32'd0);
  assign w_wr_en = w_do_acc && w_we && !w_oor;
  assign w_rd_en = w_do_acc && !w_we;

  // Hold request is combinational so the requester freezes in the same
  // cycle it asks; forced low while reset is asserted.
  assign stall_o    = rst_i && ram_ce_i && (r_state != RESP);
  assign err_o      = r_err;
  assign ram_data_o = w_rdata;

  // Handshake FSM, wait counter, request latches and error pulse.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_sel   <= 4'b0000;
      r_addr  <= 32'h0000_0000;
      r_wdata <= 32'h0000_0000;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_do_acc && w_oor;
      case (r_state)
        IDLE: begin
          if (ram_ce_i) begin
            r_we    <= ram_we_i;
            r_sel   <= ram_sel_i;
            r_addr  <= ram_addr_i;
            r_wdata <= ram_wdata_i;
            r_cnt   <= CNT_W'(WAIT_CYCLES);
            r_state <= (WAIT_CYCLES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (!ram_ce_i) begin
            // Requester withdrew (flush): drop the access entirely.
            r_state <= IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
              r_state <= RESP;
            end
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  data_ram_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .i_clk     (clk_i),
    .i_rst_n   (rst_i),
    .i_wr_en   (w_wr_en),
    .i_rd_en   (w_rd_en),
    .i_rd_zero (w_oor),
    .i_addr    (w_addr[ADDR_W+1:2]),
    .i_sel     (w_sel),
    .i_wdata   (w_wdata),
    .o_rdata   (w_rdata)
  );

endmodule

// File: tb/tb_data_ram_slave.sv
// Bench for data_ram_slave: three instances (WAIT_CYCLES 0, 1, 3) driven one
// at a time from a transaction-level driver. A per-instance word array models
// memory; expected stall/data/err per cycle follow from the access timing
// rules and are checked every negative edge.
module tb_data_ram_slave;

  localparam int NI = 3;

`ifdef DATA_RAM_RANGE_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        ce    [NI];
  logic        we    [NI];
  logic [31:0] addr  [NI];
  logic [3:0]  sel   [NI];
  logic [31:0] wdata [NI];
  logic [31:0] dout  [NI];
  logic        stall [NI];
  logic        err   [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    data_ram_slave #(
      .ADDR_W      (10),
      .WAIT_CYCLES ((g == 0) ? 0 : ((g == 1) ? 1 : 3))
    ) u_dut (
      .clk_i       (clk),
      .rst_i       (rst_n),
      .ram_ce_i    (ce[g]),
      .ram_we_i    (we[g]),
      .ram_addr_i  (addr[g]),
      .ram_sel_i   (sel[g]),
      .ram_wdata_i (wdata[g]),
      .ram_data_o  (dout[g]),
      .stall_o     (stall[g]),
      .err_o       (err[g])
    );
  end

  function automatic int wc(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
  endfunction

  int          n_checks = 0;
  int          n_err    = 0;
  logic [31:0] mdl [NI][64];
  logic        exp_stall [NI];
  logic        exp_err   [NI];
  logic [31:0] exp_data  [NI];
  int          stall_cnt [NI];
  int          err_cnt   [NI];
  bit          cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Per-cycle comparison of every instance against the expected outputs.
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < NI; k++) begin
        chk($sformatf("stall%0d", k), {31'd0, stall[k]}, {31'd0, exp_stall[k]});
        chk($sformatf("data%0d", k), dout[k], exp_data[k]);
        chk($sformatf("err%0d", k), {31'd0, err[k]}, {31'd0, exp_err[k]});
        if (stall[k] === 1'b1) stall_cnt[k]++;
        if (err[k] === 1'b1) err_cnt[k]++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    ce[k] = 1'b0;
    we[k] = 1'b0;
    exp_stall[k] = 1'b0;
    exp_err[k] = 1'b0;
    tick();
  endtask

  // One access: request cycle, WAIT cycles (optionally withdrawn at WAIT
  // cycle abort_at), then the RESP cycle. With b2b, garbage is presented
  // during RESP, which the slave must ignore.
  task automatic access(input int k, input bit w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, input int abort_at, input bit b2b);
    int W;
    bit oor;
    int word;
    W = wc(k);
    oor = CHK && (a[31:12] != 20'd0);
    word = int'(a[7:2]);
    ce[k] = 1'b1; we[k] = w; addr[k] = a; sel[k] = s; wdata[k] = d;
    exp_stall[k] = 1'b1;
    exp_err[k] = 1'b0;
    tick();
    for (int j = 1; j <= W; j++) begin
      if (j == abort_at) begin
        ce[k] = 1'b0;
        exp_stall[k] = 1'b0;
        tick();
        return;
      end
      tick();
    end
    if (w) begin
      if (!oor) begin
        for (int b = 0; b < 4; b++) begin
          if (s[b]) mdl[k][word][8*b +: 8] = d[8*b +: 8];
        end
      end
    end else begin
      exp_data[k] = oor ? 32'd0 : mdl[k][word];
    end
    exp_stall[k] = 1'b0;
    exp_err[k] = oor;
    if (b2b) begin
      ce[k] = 1'b1; we[k] = 1'($urandom); addr[k] = $urandom;
      sel[k] = 4'($urandom); wdata[k] = $urandom;
    end else begin
      ce[k] = 1'b0;
    end
    tick();
    exp_err[k] = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int s0;
    int e0;
    logic [31:0] old;
    logic [31:0] a;
    logic [19:0] up;
    int k;
    int ab;
    bit b2b;

    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      ce[i] = 1'b1; we[i] = 1'b1; addr[i] = 32'h0; sel[i] = 4'hF; wdata[i] = 32'h0;
      exp_stall[i] = 1'b0; exp_err[i] = 1'b0; exp_data[i] = 32'h0;
    end
    #1;
    cmp_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_stall_with_ce", {31'd0, stall[1]}, 32'd0);
    chk("reset_data", dout[2], 32'd0);
    for (int i = 0; i < NI; i++) ce[i] = 1'b0;
    rst_n = 1'b1;
    tick();

    // Fill the tested region of each instance with known data.
    for (int i = 0; i < NI; i++) begin
      for (int w = 0; w < 64; w++) begin
        access(i, 1'b1, 32'(w) << 2, 4'hF, $urandom, -1, 1'b1);
      end
      idle(i);
    end

    // WAIT_CYCLES=1: full write then read, two stall cycles each.
    s0 = stall_cnt[1];
    access(1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, -1, 1'b0);
    access(1, 1'b0, 32'h10, 4'hF, 32'h0, -1, 1'b0);
    chk("rd_deadbeef", dout[1], 32'hDEADBEEF);
    chk("stall_cycles_w1", 32'(stall_cnt[1] - s0), 32'd4);

    // Single-lane write with byte-offset address.
    access(1, 1'b1, 32'h12, 4'b0001, 32'h000000AA, -1, 1'b0);
    access(1, 1'b0, 32'h10, 4'hF, 32'h0, -1, 1'b0);
    chk("rd_lane0_merge", dout[1], 32'hDEADBEAA);

    // Upper address bits: aliasing or range error.
    access(1, 1'b1, 32'h0, 4'hF, 32'hCAFEF00D, -1, 1'b0);
    e0 = err_cnt[1];
    access(1, 1'b0, 32'h00001000, 4'hF, 32'h0, -1, 1'b0);
    chk("rd_upper_bits", dout[1], CHK ? 32'h0 : 32'hCAFEF00D);
    chk("err_pulses", 32'(err_cnt[1] - e0), CHK ? 32'd1 : 32'd0);

    // WAIT_CYCLES=0: back-to-back reads, one stall cycle each.
    access(0, 1'b1, 32'h0, 4'hF, 32'h11111111, -1, 1'b1);
    access(0, 1'b1, 32'h4, 4'hF, 32'h22222222, -1, 1'b1);
    s0 = stall_cnt[0];
    access(0, 1'b0, 32'h0, 4'hF, 32'h0, -1, 1'b1);
    chk("b2b_rd0", dout[0], 32'h11111111);
    access(0, 1'b0, 32'h4, 4'hF, 32'h0, -1, 1'b0);
    chk("b2b_rd4", dout[0], 32'h22222222);
    chk("stall_cycles_w0", 32'(stall_cnt[0] - s0), 32'd2);

    // WAIT_CYCLES=3: write withdrawn after one WAIT cycle must not land.
    access(2, 1'b1, 32'h20, 4'hF, 32'h0BADC0DE, -1, 1'b0);
    access(2, 1'b1, 32'h20, 4'hF, 32'h12345678, 2, 1'b0);
    access(2, 1'b0, 32'h20, 4'hF, 32'h0, -1, 1'b0);
    chk("abort_no_write", dout[2], 32'h0BADC0DE);

    // Reset asserted in the middle of a WAIT phase.
    old = mdl[2][9];
    ce[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h24; sel[2] = 4'hF; wdata[2] = 32'hF00DFACE;
    exp_stall[2] = 1'b1;
    tick();
    tick();
    #1;
    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      exp_stall[i] = 1'b0; exp_data[i] = 32'h0; exp_err[i] = 1'b0;
    end
    #1;
    chk("rst_mid_wait_stall", {31'd0, stall[2]}, 32'd0);
    chk("rst_mid_wait_data", dout[2], 32'd0);
    @(posedge clk);
    #1;
    ce[2] = 1'b0;
    rst_n = 1'b1;
    tick();
    access(2, 1'b0, 32'h24, 4'hF, 32'h0, -1, 1'b0);
    chk("rst_mem_kept", dout[2], old);

    // Randomized traffic across instances.
    for (int it = 0; it < 450; it++) begin
      k = $urandom_range(0, NI - 1);
      for (int j = 0; j < NI; j++) begin
        if (j != k) ce[j] = 1'b0;
      end
      up = ($urandom_range(0, 7) == 0) ? 20'($urandom_range(1, 20'hFFFFF)) : 20'd0;
      a = {up, 4'd0, 6'($urandom_range(0, 63)), 2'($urandom)};
      ab = -1;
      if (wc(k) > 0 && $urandom_range(0, 5) == 0) ab = $urandom_range(1, wc(k));
      b2b = 1'($urandom);
      access(k, 1'($urandom), a, 4'($urandom), $urandom, ab, b2b);
      if (!b2b) begin
        repeat ($urandom_range(0, 2)) idle(k);
      end
    end

    for (int i = 0; i < NI; i++) ce[i] = 1'b0;
    for (int i = 0; i < NI; i++) idle(i);
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
